adc_conv_sequencer: RTL and testbench

ADC_CONV_SEQUENCER -- requirements
Module: adc_conv_sequencer

---
 rtl/adc_seq_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/adc_conv_sequencer.sv | 142 ++++++++++++++
 tb/tb_adc_conv_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types and default constants for the ramp-ADC conversion sequencer.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

    localparam int unsigned DEF_NUM_CH      = 4;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_SETTLE_CYC  = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 300;

    // One timer serves both SETTLE and WAIT; it only counts to (limit - 1).
    function automatic int unsigned tmr_width(input int unsigned settle_cyc,
                                              input int unsigned timeout_cyc);
        int unsigned m;
        m = (settle_cyc > timeout_cyc) ? settle_cyc : timeout_cyc;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from the channel after ptr_i.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     pend_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int unsigned      cand;
    logic [IDX_W-1:0] c_idx;
    logic             found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = 0;
        c_idx = '0;
        found = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand  = (32'(ptr_i) + off) % N;
            c_idx = IDX_W'(cand);
            if (!found && pend_i[c_idx]) begin
                found        = 1'b1;
                gnt_o[c_idx] = 1'b1;
                idx_o        = c_idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/adc_conv_sequencer.sv
// Multiplexes NUM_CH channel requests onto one ramp ADC: settle mux, start,
// wait for the result (or time out) and publish it with its channel tag.
module adc_conv_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      adc_restart,
    input  logic                      adc_busy,
    input  logic                      adc_valid,
    input  logic [CNT_W-1:0]          adc_count,
    output logic [CNT_W-1:0]          res_data,
    output logic [$clog2(NUM_CH)-1:0] res_ch,
    output logic                      res_valid,
    output logic                      res_timeout,
    output logic                      seq_busy
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned TMR_W = tmr_width(SETTLE_CYC, TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);

    seq_state_e        state_q;
    logic [NUM_CH-1:0] pending_q, pending_d, clr_mask;
    logic [NUM_CH-1:0] gnt_q;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [CH_W-1:0]   ch_sel_q, res_ch_q;
    logic [CNT_W-1:0]  res_data_q;
    logic              restart_q, res_valid_q, res_timeout_q, seq_busy_q;

    logic [NUM_CH-1:0] arb_gnt;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_any;

    rr_arbiter #(
        .N     (NUM_CH),
        .IDX_W (CH_W)
    ) u_arb (
        .pend_i (pending_q),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    // A new req in the DONE cycle re-arms the channel being cleared.
    always_comb begin
        clr_mask  = (state_q == ST_DONE) ? gnt_q : '0;
        pending_d = (pending_q & ~clr_mask) | req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            gnt_q         <= '0;
            rr_ptr_q      <= CH_W'(NUM_CH - 1);
            tmr_q         <= '0;
            ch_sel_q      <= '0;
            restart_q     <= 1'b0;
            res_data_q    <= '0;
            res_ch_q      <= '0;
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            seq_busy_q    <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            restart_q   <= 1'b0;
            res_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_any && !adc_busy) begin
                        state_q    <= ST_SETTLE;
                        ch_sel_q   <= arb_idx;
                        rr_ptr_q   <= arb_idx;
                        gnt_q      <= arb_gnt;
                        tmr_q      <= '0;
                        seq_busy_q <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_q == SETTLE_LAST) begin
                        state_q   <= ST_START;
                        restart_q <= 1'b1;
                        tmr_q     <= '0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                    tmr_q   <= '0;
                end
                ST_WAIT: begin
                    // A result arriving on the last allowed cycle beats the timeout.
                    if (adc_valid) begin
                        res_data_q    <= adc_count;
                        res_timeout_q <= 1'b0;
                    end else if (tmr_q == TIMEOUT_LAST) begin
                        res_data_q    <= '0;
                        res_timeout_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                    if (adc_valid || (tmr_q == TIMEOUT_LAST)) begin
                        state_q     <= ST_DONE;
                        res_valid_q <= 1'b1;
                        res_ch_q    <= ch_sel_q;
                    end
                end
                ST_DONE: begin
                    state_q       <= ST_IDLE;
                    seq_busy_q    <= 1'b0;
                    res_timeout_q <= 1'b0;
                    tmr_q         <= '0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    seq_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign ch_sel      = ch_sel_q;
    assign adc_restart = restart_q;
    assign res_data    = res_data_q;
    assign res_ch      = res_ch_q;
    assign res_valid   = res_valid_q;
    assign res_timeout = res_timeout_q;
    assign seq_busy    = seq_busy_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer with a delay-programmable ADC responder.
module tb_adc_conv_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic [1:0] ch_sel;
    logic       adc_restart;
    logic       adc_busy = 1'b0;
    logic       adc_valid;
    logic [7:0] adc_count;
    logic [7:0] res_data;
    logic [1:0] res_ch;
    logic       res_valid, res_timeout, seq_busy;

    logic        resp_valid   = 1'b0;
    logic        glitch_valid = 1'b0;
    int unsigned adc_dly      = 0;
    logic [7:0]  resp_base    = '0;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int          rs_cnt [4];
    int          rs_total = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [7:0]  data;
        logic        to;
        int unsigned cyc;
    } res_t;
    res_t rq[$];
    res_t mr;

    adc_conv_sequencer #(
        .NUM_CH      (4),
        .CNT_W       (8),
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (300)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ch_sel      (ch_sel),
        .adc_restart (adc_restart),
        .adc_busy    (adc_busy),
        .adc_valid   (adc_valid),
        .adc_count   (adc_count),
        .res_data    (res_data),
        .res_ch      (res_ch),
        .res_valid   (res_valid),
        .res_timeout (res_timeout),
        .seq_busy    (seq_busy)
    );

    always #5 clk = ~clk;

    assign adc_valid = resp_valid | glitch_valid;
    assign adc_count = resp_base + {6'b0, ch_sel};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            mr.ch   = res_ch;
            mr.data = res_data;
            mr.to   = res_timeout;
            mr.cyc  = cyc;
            rq.push_back(mr);
        end
        if (adc_restart === 1'b1) begin
            rs_cnt[ch_sel] += 1;
            rs_total       += 1;
        end
    end

    // ADC model: valid arrives adc_dly cycles after the restart cycle (0 = never).
    initial begin
        forever begin
            @(negedge clk);
            if (adc_restart === 1'b1 && adc_dly != 0) begin
                repeat (adc_dly) @(posedge clk);
                #1 resp_valid = 1'b1;
                @(posedge clk);
                #1 resp_valid = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        rq.delete();
        rs_total = 0;
        foreach (rs_cnt[i]) rs_cnt[i] = 0;
    endtask

    task automatic pulse_req(input logic [3:0] v, output int unsigned c0);
        @(negedge clk);
        req = v;
        c0  = cyc;
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (ch_sel !== 2'd0) begin bad++; $display("FAIL rst_ch_sel: got %0h want 0", ch_sel); end
        total++; if (adc_restart !== 1'b0) begin bad++; $display("FAIL rst_restart: got %0b want 0", adc_restart); end
        total++; if (res_data !== 8'h00) begin bad++; $display("FAIL rst_res_data: got %0h want 0", res_data); end
        total++; if (res_ch !== 2'd0) begin bad++; $display("FAIL rst_res_ch: got %0h want 0", res_ch); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid: got %0b want 0", res_valid); end
        total++; if (res_timeout !== 1'b0) begin bad++; $display("FAIL rst_res_timeout: got %0b want 0", res_timeout); end
        total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL rst_seq_busy: got %0b want 0", seq_busy); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int unsigned c0;
        do_reset();
        adc_dly   = 10;
        resp_base = 8'h58;
        pulse_req(4'b0100, c0);
        repeat (5) @(negedge clk);
        total++; if (adc_restart !== 1'b1) begin bad++; $display("FAIL single_restart: got %0b want 1", adc_restart); end
        total++; if (ch_sel !== 2'd2) begin bad++; $display("FAIL single_ch_sel: got %0d want 2", ch_sel); end
        total++; if (seq_busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b want 1", seq_busy); end
        for (int i = 0; i < 60 && rq.size() < 1; i++) @(negedge clk);
        total++;
        if (rq.size() != 1) begin
            bad++; $display("FAIL single_count: got %0d results want 1", rq.size());
        end else begin
            total++; if (rq[0].ch !== 2'd2) begin bad++; $display("FAIL single_ch: got %0d want 2", rq[0].ch); end
            total++; if (rq[0].data !== 8'h5A) begin bad++; $display("FAIL single_data: got %0h want 5a", rq[0].data); end
            total++; if (rq[0].to !== 1'b0) begin bad++; $display("FAIL single_to: got %0b want 0", rq[0].to); end
            total++; if (rq[0].cyc - c0 != 17) begin bad++; $display("FAIL single_latency: got %0d want 17", rq[0].cyc - c0); end
        end
        repeat (2) @(negedge clk);
        total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %0b want 0", seq_busy); end
        total++; if (rs_cnt[2] != 1) begin bad++; $display("FAIL single_restarts: got %0d want 1", rs_cnt[2]); end
    endtask

    task automatic test_all4();
        int unsigned c0;
        logic [7:0]  exp_d;
        do_reset();
        adc_dly   = 3;
        resp_base = 8'h10;
        pulse_req(4'b1111, c0);
        for (int i = 0; i < 100 && rq.size() < 4; i++) @(negedge clk);
        total++;
        if (rq.size() != 4) begin
            bad++; $display("FAIL all4_count: got %0d results want 4", rq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_d = 8'h10 + 8'(k);
                total++; if (rq[k].ch !== 2'(k)) begin bad++; $display("FAIL all4_order[%0d]: got %0d want %0d", k, rq[k].ch, k); end
                total++; if (rq[k].data !== exp_d) begin bad++; $display("FAIL all4_data[%0d]: got %0h want %0h", k, rq[k].data, exp_d); end
                total++; if (rq[k].cyc - c0 != 10 * (k + 1)) begin bad++; $display("FAIL all4_time[%0d]: got %0d want %0d", k, rq[k].cyc - c0, 10 * (k + 1)); end
                total++; if (rs_cnt[k] != 1) begin bad++; $display("FAIL all4_restarts[%0d]: got %0d want 1", k, rs_cnt[k]); end
            end
        end
    endtask

    task automatic test_timeout();
        int unsigned c0;
        do_reset();
        adc_dly   = 0;
        resp_base = 8'h20;
        pulse_req(4'b0011, c0);
        for (int i = 0; i < 400 && rq.size() < 1; i++) @(negedge clk);
        adc_dly = 5;
        total++;
        if (rq.size() < 1) begin
            bad++; $display("FAIL to_count: got %0d results want 1", rq.size());
        end else begin
            total++; if (rq[0].ch !== 2'd0) begin bad++; $display("FAIL to_ch: got %0d want 0", rq[0].ch); end
            total++; if (rq[0].to !== 1'b1) begin bad++; $display("FAIL to_flag: got %0b want 1", rq[0].to); end
            total++; if (rq[0].data !== 8'h00) begin bad++; $display("FAIL to_data: got %0h want 0", rq[0].data); end
            total++; if (rq[0].cyc - c0 != 307) begin bad++; $display("FAIL to_latency: got %0d want 307", rq[0].cyc - c0); end
        end
        for (int i = 0; i < 60 && rq.size() < 2; i++) @(negedge clk);
        total++;
        if (rq.size() != 2) begin
            bad++; $display("FAIL to_next_count: got %0d results want 2", rq.size());
        end else begin
            total++; if (rq[1].ch !== 2'd1) begin bad++; $display("FAIL to_next_ch: got %0d want 1", rq[1].ch); end
            total++; if (rq[1].to !== 1'b0) begin bad++; $display("FAIL to_next_flag: got %0b want 0", rq[1].to); end
            total++; if (rq[1].data !== 8'h21) begin bad++; $display("FAIL to_next_data: got %0h want 21", rq[1].data); end
            total++; if (rq[1].cyc - c0 != 319) begin bad++; $display("FAIL to_next_time: got %0d want 319", rq[1].cyc - c0); end
        end
    endtask

    task automatic test_timeout_edge();
        int unsigned c0, c1;
        do_reset();
        adc_dly   = 300;
        resp_base = 8'h60;
        pulse_req(4'b0001, c0);
        for (int i = 0; i < 400 && rq.size() < 1; i++) @(negedge clk);
        total++;
        if (rq.size() != 1) begin
            bad++; $display("FAIL edge_count: got %0d results want 1", rq.size());
        end else begin
            total++; if (rq[0].to !== 1'b0) begin bad++; $display("FAIL edge_valid_wins: got %0b want 0", rq[0].to); end
            total++; if (rq[0].data !== 8'h60) begin bad++; $display("FAIL edge_data: got %0h want 60", rq[0].data); end
            total++; if (rq[0].cyc - c0 != 307) begin bad++; $display("FAIL edge_time: got %0d want 307", rq[0].cyc - c0); end
        end
        repeat (2) @(negedge clk);
        adc_dly = 301;
        pulse_req(4'b0001, c1);
        for (int i = 0; i < 400 && rq.size() < 2; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        total++;
        if (rq.size() != 2) begin
            bad++; $display("FAIL late_count: got %0d results want 2", rq.size());
        end else begin
            total++; if (rq[1].to !== 1'b1) begin bad++; $display("FAIL late_to: got %0b want 1", rq[1].to); end
            total++; if (rq[1].data !== 8'h00) begin bad++; $display("FAIL late_data: got %0h want 0", rq[1].data); end
            total++; if (rq[1].cyc - c1 != 307) begin bad++; $display("FAIL late_time: got %0d want 307", rq[1].cyc - c1); end
        end
    endtask

    task automatic test_rearm();
        int unsigned c0;
        do_reset();
        adc_dly   = 2;
        resp_base = 8'h40;
        pulse_req(4'b0010, c0);
        for (int i = 0; i < 40 && res_valid !== 1'b1; i++) @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 40 && rq.size() < 2; i++) @(negedge clk);
        total++;
        if (rq.size() != 2) begin
            bad++; $display("FAIL rearm_count: got %0d results want 2", rq.size());
        end else begin
            total++; if (rq[0].ch !== 2'd1 || rq[1].ch !== 2'd1) begin bad++; $display("FAIL rearm_ch: got %0d,%0d want 1,1", rq[0].ch, rq[1].ch); end
            total++; if (rq[0].cyc - c0 != 9) begin bad++; $display("FAIL rearm_first_time: got %0d want 9", rq[0].cyc - c0); end
            total++; if (rq[1].cyc - c0 != 18) begin bad++; $display("FAIL rearm_second_time: got %0d want 18", rq[1].cyc - c0); end
            total++; if (rs_cnt[1] != 2) begin bad++; $display("FAIL rearm_restarts: got %0d want 2", rs_cnt[1]); end
        end
    endtask

    task automatic test_busy_hold();
        int unsigned c0, k;
        do_reset();
        adc_dly   = 2;
        resp_base = 8'h70;
        adc_busy  = 1'b1;
        pulse_req(4'b0001, c0);
        repeat (10) @(negedge clk);
        total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL busy_hold_state: got %0b want 0", seq_busy); end
        total++; if (rs_total != 0) begin bad++; $display("FAIL busy_hold_restarts: got %0d want 0", rs_total); end
        adc_busy = 1'b0;
        k = cyc;
        for (int i = 0; i < 40 && rq.size() < 1; i++) @(negedge clk);
        total++;
        if (rq.size() != 1) begin
            bad++; $display("FAIL busy_release_count: got %0d results want 1", rq.size());
        end else begin
            total++; if (rq[0].ch !== 2'd0) begin bad++; $display("FAIL busy_release_ch: got %0d want 0", rq[0].ch); end
            total++; if (rq[0].data !== 8'h70) begin bad++; $display("FAIL busy_release_data: got %0h want 70", rq[0].data); end
            total++; if (rq[0].cyc - k != 8) begin bad++; $display("FAIL busy_release_time: got %0d want 8", rq[0].cyc - k); end
        end
    endtask

    task automatic test_settle_glitch();
        int unsigned c0;
        do_reset();
        adc_dly   = 4;
        resp_base = 8'h30;
        pulse_req(4'b1000, c0);
        repeat (2) @(negedge clk);
        glitch_valid = 1'b1;
        total++; if (seq_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy: got %0b want 1", seq_busy); end
        total++; if (ch_sel !== 2'd3) begin bad++; $display("FAIL glitch_ch_sel: got %0d want 3", ch_sel); end
        total++; if (adc_restart !== 1'b0) begin bad++; $display("FAIL glitch_restart: got %0b want 0", adc_restart); end
        @(negedge clk);
        glitch_valid = 1'b0;
        for (int i = 0; i < 40 && rq.size() < 1; i++) @(negedge clk);
        total++;
        if (rq.size() != 1) begin
            bad++; $display("FAIL glitch_count: got %0d results want 1", rq.size());
        end else begin
            total++; if (rq[0].ch !== 2'd3) begin bad++; $display("FAIL glitch_ch: got %0d want 3", rq[0].ch); end
            total++; if (rq[0].data !== 8'h33) begin bad++; $display("FAIL glitch_data: got %0h want 33", rq[0].data); end
            total++; if (rq[0].to !== 1'b0) begin bad++; $display("FAIL glitch_to: got %0b want 0", rq[0].to); end
            total++; if (rq[0].cyc - c0 != 11) begin bad++; $display("FAIL glitch_time: got %0d want 11", rq[0].cyc - c0); end
            total++; if (rs_cnt[3] != 1) begin bad++; $display("FAIL glitch_restarts: got %0d want 1", rs_cnt[3]); end
        end
    endtask

    task automatic test_reset_mid();
        int unsigned c0, c1;
        do_reset();
        adc_dly   = 2;
        resp_base = 8'hC0;
        pulse_req(4'b0100, c0);
        for (int i = 0; i < 40 && rq.size() < 1; i++) @(negedge clk);
        adc_dly = 0;
        pulse_req(4'b1010, c1);
        repeat (10) @(negedge clk);
        total++; if (seq_busy !== 1'b1) begin bad++; $display("FAIL mid_pre_busy: got %0b want 1", seq_busy); end
        rst = 1'b1;
        req = 4'b1000;
        @(negedge clk);
        total++; if (ch_sel !== 2'd0) begin bad++; $display("FAIL mid_ch_sel: got %0d want 0", ch_sel); end
        total++; if (res_data !== 8'h00) begin bad++; $display("FAIL mid_res_data: got %0h want 0", res_data); end
        total++; if (res_ch !== 2'd0) begin bad++; $display("FAIL mid_res_ch: got %0d want 0", res_ch); end
        total++; if (res_valid !== 1'b0 || res_timeout !== 1'b0) begin bad++; $display("FAIL mid_res_flags: got %0b%0b want 00", res_valid, res_timeout); end
        total++; if (seq_busy !== 1'b0 || adc_restart !== 1'b0) begin bad++; $display("FAIL mid_busy_restart: got %0b%0b want 00", seq_busy, adc_restart); end
        rst = 1'b0;
        req = '0;
        adc_dly = 3;
        rq.delete();
        rs_total = 0;
        repeat (40) @(negedge clk);
        total++; if (rq.size() != 0) begin bad++; $display("FAIL mid_no_result: got %0d results want 0", rq.size()); end
        total++; if (rs_total != 0) begin bad++; $display("FAIL mid_pending_dropped: got %0d restarts want 0", rs_total); end
        total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL mid_idle: got %0b want 0", seq_busy); end
    endtask

    initial begin
        foreach (rs_cnt[i]) rs_cnt[i] = 0;
        test_reset();
        test_single();
        test_all4();
        test_timeout();
        test_timeout_edge();
        test_rearm();
        test_busy_hold();
        test_settle_glitch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
